// File: rtl/ras_ckpt_pkg.sv
// Shared return-address-stack sizing and checkpoint bundle for the frontend predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default RAS geometry and the widths derived from it, so that the
// branch-tag queue and the stack agree on checkpoint field sizes.
package ras_ckpt_pkg;

  localparam int RAS_DEPTH = 3;
  localparam int RAS_VLEN  = 32;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  // Snapshot taken alongside every predicted branch; replayed on mispredict.
  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_CNT_W-1:0] cnt;
    logic [RAS_VLEN-1:0]  data;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Predictor <-> RAS bundle: push/pop/flush controls, top-of-stack view, checkpoint and restore.
// Latency: n/a (wires only).
// Backpressure: none; the stack accepts an operation every cycle.
//
// master: predictor side (drives controls and restore, reads top and checkpoint).
// slave : stack side.
interface ras_ckpt_if
  import ras_ckpt_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int VLEN  = RAS_VLEN
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic [PtrW-1:0] ckpt_ptr_o;
  logic [CntW-1:0] ckpt_cnt_o;
  logic [VLEN-1:0] ckpt_data_o;
  logic            restore_i;
  logic [PtrW-1:0] restore_ptr_i;
  logic [CntW-1:0] restore_cnt_i;
  logic [VLEN-1:0] restore_data_i;

  modport master (
    output flush_i, push_i, pop_i, data_i,
    output restore_i, restore_ptr_i, restore_cnt_i, restore_data_i,
    input  data_o, valid_o, ckpt_ptr_o, ckpt_cnt_o, ckpt_data_o
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i,
    input  restore_i, restore_ptr_i, restore_cnt_i, restore_data_i,
    output data_o, valid_o, ckpt_ptr_o, ckpt_cnt_o, ckpt_data_o
  );

endinterface

// File: rtl/ras_ckpt.sv
// Circular return-address stack (any DEPTH >= 2) with checkpoint/restore for mispredict recovery.
// Latency: top/valid reflect an operation one cycle later; checkpoint outputs show current state (no bypass).
// Backpressure: none; overflow overwrites the oldest entry, pop on empty is ignored.
//
// Ports: clk_i, rst_ni (async, active low); bus (ras_ckpt_if.slave) carrying
//   flush_i/push_i/pop_i/data_i, restore_i/restore_ptr_i/restore_cnt_i/restore_data_i in,
//   data_o/valid_o/ckpt_ptr_o/ckpt_cnt_o/ckpt_data_o out.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int VLEN  = RAS_VLEN
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  ras_ckpt_if.slave   bus
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_depth_chk
    $error("ras_ckpt: DEPTH must be at least 2");
  end

  logic [PtrW-1:0] r_tos;
  logic [CntW-1:0] r_cnt;
  logic [VLEN-1:0] r_mem [DEPTH];

  logic [PtrW-1:0] w_tos_nxt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_wr_en;
  logic [PtrW-1:0] w_wr_ptr;
  logic [VLEN-1:0] w_wr_dat;

  // Explicit wrap at DEPTH-1 so non-power-of-2 depths never index past the array.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(DEPTH - 1) : p - 1'b1;
  endfunction

  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_ptr  = r_tos;
    w_wr_dat  = bus.data_i;
    if (bus.flush_i) begin
      // Storage is left as-is; it is unobservable through valid_o while cnt is 0.
      w_tos_nxt = '0;
      w_cnt_nxt = '0;
    end else if (bus.restore_i) begin
      // Rewrite the checkpointed top entry in case wrong-path pushes clobbered it.
      w_tos_nxt = bus.restore_ptr_i;
      w_cnt_nxt = bus.restore_cnt_i;
      w_wr_en   = (bus.restore_cnt_i != '0);
      w_wr_ptr  = bus.restore_ptr_i;
      w_wr_dat  = bus.restore_data_i;
    end else if (bus.push_i && bus.pop_i) begin
      // Coroutine swap: replace the top in place.
      w_wr_en   = 1'b1;
      w_cnt_nxt = (r_cnt == '0) ? CntW'(1) : r_cnt;
    end else if (bus.push_i) begin
      w_tos_nxt = ptr_inc(r_tos);
      w_wr_en   = 1'b1;
      w_wr_ptr  = ptr_inc(r_tos);
      w_cnt_nxt = (r_cnt == CntW'(DEPTH)) ? r_cnt : r_cnt + 1'b1;
    end else if (bus.pop_i && (r_cnt != '0)) begin
      w_tos_nxt = ptr_dec(r_tos);
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tos <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_tos <= w_tos_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_wr_en) begin
        r_mem[w_wr_ptr] <= w_wr_dat;
      end
    end
  end

  assign bus.data_o      = r_mem[r_tos];
  assign bus.valid_o     = (r_cnt != '0);
  assign bus.ckpt_ptr_o  = r_tos;
  assign bus.ckpt_cnt_o  = r_cnt;
  assign bus.ckpt_data_o = r_mem[r_tos];

  a_restore_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.restore_i |-> ((int'(bus.restore_ptr_i) < DEPTH) && (int'(bus.restore_cnt_i) <= DEPTH)));

  a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(r_cnt) <= DEPTH);

endmodule
